// File: rtl/axi4_stream_operand_unpacker.sv
// Rebuilds two SZ-bit operands from a tlast-framed DSZ-bit stream; op_valid one cycle after the last beat.
// Backpressure: s_tready drops while a decoded frame waits in HOLD for op_ready; malformed frames are dropped and counted.
module axi4_stream_operand_unpacker #(
  parameter int SZ  = 32,
  parameter int DSZ = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DSZ-1:0] s_tdata,
  input  logic           s_tvalid,
  output logic           s_tready,
  input  logic           s_tlast,
  output logic [SZ-1:0]  op_a,
  output logic [SZ-1:0]  op_b,
  output logic           op_valid,
  input  logic           op_ready,
  output logic           frame_err,
  output logic [7:0]     err_cnt
);

  localparam int BEATS = 2 * SZ / DSZ;
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [1:0] {COLLECT, HOLD, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*SZ-1:0] frame_q, frame_d;
  logic            err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            beat;

  assign s_tready  = (state_q == COLLECT || state_q == DRAIN) && !rst;
  assign beat      = s_tvalid && s_tready;
  assign op_a      = frame_q[SZ-1:0];
  assign op_b      = frame_q[2*SZ-1:SZ];
  assign op_valid  = (state_q == HOLD);
  assign frame_err = err_q;
  assign err_cnt   = err_cnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    case (state_q)
      COLLECT: begin
        if (beat) begin
          if (cnt_q != LAST_BEAT) begin
            if (!s_tlast) begin
              frame_d[cnt_q*DSZ +: DSZ] = s_tdata;
              cnt_d = cnt_q + CW'(1);
            end else begin
              cnt_d     = '0;
              err_d     = 1'b1;
              err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            end
          end else begin
            cnt_d = '0;
            if (s_tlast) begin
              frame_d[cnt_q*DSZ +: DSZ] = s_tdata;
              state_d = HOLD;
            end else begin
              // Overlong frame: flag once here, then swallow the rest silently in DRAIN.
              err_d     = 1'b1;
              err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
              state_d   = DRAIN;
            end
          end
        end
      end
      HOLD: begin
        if (op_ready) state_d = COLLECT;
      end
      DRAIN: begin
        if (beat && s_tlast) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      frame_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi4_stream_operand_unpacker.sv
// Randomized bench for axi4_stream_operand_unpacker with a frame-level reference model.
`timescale 1ns/1ps
module tb_axi4_stream_operand_unpacker;
  localparam int SZ = 32;
  localparam int DSZ = 8;
  localparam int BEATS = 2 * SZ / DSZ;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [DSZ-1:0] s_tdata;
  logic           s_tvalid;
  logic           s_tready;
  logic           s_tlast;
  logic [SZ-1:0]  op_a;
  logic [SZ-1:0]  op_b;
  logic           op_valid;
  logic           op_ready;
  logic           frame_err;
  logic [7:0]     err_cnt;

  axi4_stream_operand_unpacker #(.SZ(SZ), .DSZ(DSZ)) dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  int total = 0;
  int bad = 0;
  logic [DSZ-1:0] tx [0:15];
  logic [2*SZ-1:0] got_q[$];
  logic [2*SZ-1:0] exp_q[$];
  int exp_err = 0;
  int exp_pulses = 0;
  int seen_pulses = 0;

  // Monitor: handshakes and error-pulse cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (op_valid && op_ready) got_q.push_back({op_b, op_a});
      if (frame_err) seen_pulses++;
    end
  end

  // Reference: a frame is good only if it has exactly BEATS beats with tlast on the last one.
  task automatic model_frame(input int n);
    logic [2*SZ-1:0] v;
    if (n == BEATS) begin
      v = '0;
      for (int k = 0; k < BEATS; k++) v = v | ((2*SZ)'(tx[k]) << (DSZ * k));
      exp_q.push_back(v);
    end else begin
      exp_pulses++;
      if (exp_err < 255) exp_err++;
    end
  endtask

  task automatic load_ab(input logic [SZ-1:0] a, input logic [SZ-1:0] b);
    logic [2*SZ-1:0] v;
    v = {b, a};
    for (int k = 0; k < BEATS; k++) tx[k] = v[k*DSZ +: DSZ];
  endtask

  task automatic load_random();
    for (int k = 0; k < 16; k++) tx[k] = DSZ'($urandom);
  endtask

  task automatic drive_beat(input logic [DSZ-1:0] d, input logic last, input bit gaps);
    int budget;
    bit accepted;
    if (gaps && $urandom_range(0, 1) == 1) begin
      repeat ($urandom_range(1, 3)) begin
        s_tvalid = 1'b0;
        s_tdata  = DSZ'($urandom);
        s_tlast  = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    budget   = 0;
    accepted = 1'b0;
    while (!accepted && budget < 200) begin
      @(negedge clk);
      if (s_tready) accepted = 1'b1;
      @(posedge clk); #1;
      budget++;
    end
    if (!accepted) begin
      total++; bad++;
      $display("FAIL beat_timeout: s_tready=%0b after %0d cycles, required 1", s_tready, budget);
    end
  endtask

  task automatic send_frame(input int n, input bit gaps);
    for (int i = 0; i < n; i++) drive_beat(tx[i], (i == n - 1), gaps);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    model_frame(n);
  endtask

  task automatic wait_ops();
    for (int c = 0; c < 50 && got_q.size() < exp_q.size(); c++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; op_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL rst_tready: got %0b want 0", s_tready); end
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL rst_op_valid: got %0b want 0", op_valid); end
    total++; if ({op_b, op_a} !== 64'd0) begin bad++; $display("FAIL rst_ops: got %h want 0", {op_b, op_a}); end
    total++; if (frame_err !== 1'b0 || err_cnt !== 8'd0) begin bad++; $display("FAIL rst_err: got %0b/%0d want 0/0", frame_err, err_cnt); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL post_rst_tready: got %0b want 1", s_tready); end
  endtask

  task automatic test_good_frame();
    logic [2*SZ-1:0] g;
    tx[0] = 8'hFA; tx[1] = 8'h27; tx[2] = 8'h00; tx[3] = 8'h00;
    tx[4] = 8'h36; tx[5] = 8'h02; tx[6] = 8'h00; tx[7] = 8'h00;
    op_ready = 1'b1;
    send_frame(8, 0);
    total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL t1_latency: op_valid=%0b want 1", op_valid); end
    total++; if (op_a !== 32'd10234 || op_b !== 32'd566) begin bad++; $display("FAIL t1_ops: got a=%0d b=%0d want 10234 566", op_a, op_b); end
    @(posedge clk); #1;
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL t1_one_cycle: op_valid=%0b want 0", op_valid); end
    total++;
    if (got_q.size() != 1) begin bad++; $display("FAIL t1_count: got %0d handshakes want 1", got_q.size()); end
    else begin
      g = got_q.pop_front();
      if (g !== exp_q[0]) begin bad++; $display("FAIL t1_model: got %h want %h", g, exp_q[0]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [2*SZ-1:0] e, g;
    op_ready = 1'b0;
    send_frame(8, 0);
    e = exp_q[0];
    load_random();
    s_tvalid = 1'b1; s_tdata = tx[0]; s_tlast = 1'b0;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (op_valid !== 1'b1 || s_tready !== 1'b0 || {op_b, op_a} !== e) begin
        bad++; $display("FAIL t2_hold c%0d: valid=%0b tready=%0b ops=%h want 1 0 %h", c, op_valid, s_tready, {op_b, op_a}, e);
      end
      @(posedge clk); #1;
    end
    op_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL t2_release: op_valid=%0b want 0", op_valid); end
    send_frame(8, 0);
    wait_ops();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (got_q.size() == 0) begin bad++; $display("FAIL t2_frame%0d: no handshake, want %h", k, exp_q[0]); end
      else begin
        g = got_q.pop_front();
        if (g !== exp_q[0]) begin bad++; $display("FAIL t2_frame%0d: got %h want %h", k, g, exp_q[0]); end
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_early_tlast();
    logic [2*SZ-1:0] g;
    load_random();
    send_frame(4, 0);
    total++; if (frame_err !== 1'b1 || err_cnt !== 8'(exp_err)) begin bad++; $display("FAIL t3_err: frame_err=%0b cnt=%0d want 1 %0d", frame_err, err_cnt, exp_err); end
    @(posedge clk); #1;
    total++; if (frame_err !== 1'b0 || seen_pulses != exp_pulses || got_q.size() != 0) begin
      bad++; $display("FAIL t3_pulse: frame_err=%0b pulses=%0d valid=%0d want 0 %0d 0", frame_err, seen_pulses, got_q.size(), exp_pulses);
    end
    load_ab(32'd123124, 32'd12412);
    send_frame(8, 0);
    wait_ops();
    total++;
    if (got_q.size() == 0) begin bad++; $display("FAIL t3_decode: no handshake, want a=123124 b=12412"); end
    else begin
      g = got_q.pop_front();
      if (g !== {32'd12412, 32'd123124} || g !== exp_q[0]) begin bad++; $display("FAIL t3_decode: got %h want %h", g, exp_q[0]); end
    end
    exp_q.delete();
  endtask

  task automatic test_missing_tlast();
    logic [2*SZ-1:0] g;
    load_random();
    for (int i = 0; i < 12; i++) begin
      drive_beat(tx[i], (i == 11), 0);
      if (i == 7) begin
        total++; if (frame_err !== 1'b1 || err_cnt !== 8'(exp_err + 1)) begin bad++; $display("FAIL t4_err_beat7: frame_err=%0b cnt=%0d want 1 %0d", frame_err, err_cnt, exp_err + 1); end
      end
      if (i == 8) begin
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL t4_pulse_len: frame_err=%0b want 0", frame_err); end
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    model_frame(12);
    @(posedge clk); #1;
    total++; if (seen_pulses != exp_pulses || got_q.size() != 0 || s_tready !== 1'b1) begin
      bad++; $display("FAIL t4_drain: pulses=%0d valid=%0d tready=%0b want %0d 0 1", seen_pulses, got_q.size(), s_tready, exp_pulses);
    end
    load_ab(32'd1234235, 32'd13156);
    send_frame(8, 0);
    wait_ops();
    total++;
    if (got_q.size() == 0) begin bad++; $display("FAIL t4_decode: no handshake, want %h", exp_q[0]); end
    else begin
      g = got_q.pop_front();
      if (g !== {32'd13156, 32'd1234235} || g !== exp_q[0]) begin bad++; $display("FAIL t4_decode: got %h want %h", g, exp_q[0]); end
    end
    exp_q.delete();
  endtask

  task automatic test_gaps();
    logic [2*SZ-1:0] g;
    load_ab(32'd537321351, 32'd24627837);
    send_frame(8, 1);
    wait_ops();
    total++;
    if (got_q.size() == 0) begin bad++; $display("FAIL t5_decode: no handshake, want %h", exp_q[0]); end
    else begin
      g = got_q.pop_front();
      if (g !== {32'd24627837, 32'd537321351}) begin bad++; $display("FAIL t5_decode: got %h want %h", g, {32'd24627837, 32'd537321351}); end
    end
    exp_q.delete();
    total++; if (seen_pulses != exp_pulses) begin bad++; $display("FAIL t5_no_err: pulses=%0d want %0d", seen_pulses, exp_pulses); end
  endtask

  task automatic test_reset_mid_and_saturate();
    logic [2*SZ-1:0] g;
    load_random();
    for (int i = 0; i < 5; i++) drive_beat(tx[i], 1'b0, 0);
    s_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (s_tready !== 1'b0 || op_valid !== 1'b0 || {op_b, op_a} !== 64'd0 || frame_err !== 1'b0 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL t6_reset: tready=%0b valid=%0b ops=%h err=%0b cnt=%0d want all 0", s_tready, op_valid, {op_b, op_a}, frame_err, err_cnt);
    end
    rst = 1'b0;
    exp_err = 0;
    for (int f = 0; f < 300; f++) begin
      load_random();
      send_frame($urandom_range(1, BEATS - 1), 0);
    end
    @(posedge clk); #1;
    total++; if (err_cnt !== 8'd255 || exp_err != 255) begin bad++; $display("FAIL t6_saturate: cnt=%0d want 255", err_cnt); end
    total++; if (seen_pulses != exp_pulses || got_q.size() != 0) begin bad++; $display("FAIL t6_pulses: pulses=%0d valid=%0d want %0d 0", seen_pulses, got_q.size(), exp_pulses); end
    load_random();
    send_frame(8, 1);
    wait_ops();
    total++;
    if (got_q.size() == 0) begin bad++; $display("FAIL t6_decode: no handshake, want %h", exp_q[0]); end
    else begin
      g = got_q.pop_front();
      if (g !== exp_q[0]) begin bad++; $display("FAIL t6_decode: got %h want %h", g, exp_q[0]); end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_backpressure();
    test_early_tlast();
    test_missing_tlast();
    test_gaps();
    test_reset_mid_and_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
